// File: rtl/rr_arbiter16.sv
// 16-requester round-robin arbiter with held grants, driving a 16:1 mux select.
// Optional forced release after TIMEOUT unacknowledged cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter16 #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req_i,
    input  logic        ack_i,
    output logic        grant_valid_o,
    output logic [3:0]  grant_sel_o,
    output logic [15:0] grant_onehot_o,
    output logic        timeout_o
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e      state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [3:0]  sel_q, sel_d;
    logic [15:0] onehot_q, onehot_d;

    logic [3:0]  arb_ptr;
    logic [15:0] arb_req;
    logic [31:0] arb_dbl;
    logic [15:0] arb_rot;
    logic [3:0]  arb_off;
    logic        arb_found;
    logic [3:0]  arb_win;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
    logic            expire;

    assign expire = (cnt_q == CntW'(TIMEOUT - 1));
`endif

    // In GRANT the search starts after the current holder, which is masked out.
    always_comb begin
        if (state_q == StGrant) begin
            arb_ptr = sel_q + 4'd1;
            arb_req = req_i & ~onehot_q;
        end else begin
            arb_ptr = ptr_q;
            arb_req = req_i;
        end
        arb_dbl   = {arb_req, arb_req} >> arb_ptr;
        arb_rot   = arb_dbl[15:0];
        arb_found = |arb_rot;
        arb_off   = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (arb_rot[i]) begin
                arb_off = 4'(i);
            end
        end
        arb_win = arb_ptr + arb_off;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (arb_found) begin
                    state_d = StGrant;
                    sel_d   = arb_win;
`ifdef ARB_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            StGrant: begin
                if (ack_i) begin
                    ptr_d = sel_q + 4'd1;
                    if (arb_found) begin
                        sel_d = arb_win;
`ifdef ARB_TIMEOUT_EN
                        cnt_d = '0;
`endif
                    end else begin
                        state_d = StIdle;
                    end
                end else if (!req_i[sel_q]) begin
                    ptr_d   = sel_q + 4'd1;
                    state_d = StIdle;
                end
`ifdef ARB_TIMEOUT_EN
                else if (expire) begin
                    ptr_d     = sel_q + 4'd1;
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`endif
            end
        endcase
        onehot_d = (state_d == StGrant) ? (16'h0001 << sel_d) : 16'h0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            ptr_q    <= 4'd0;
            sel_q    <= 4'd0;
            onehot_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            onehot_q <= onehot_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign grant_valid_o  = (state_q == StGrant);
    assign grant_sel_o    = sel_q;
    assign grant_onehot_o = onehot_q;

endmodule

// File: tb/tb_rr_arbiter16.sv
// Scoreboard bench for rr_arbiter16: stimulus queues expected grant events, a monitor
// pops and checks them (cycle, valid, sel, onehot, timeout) whenever the outputs change.
module tb_rr_arbiter16;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TO   = 4;
    localparam int          HOLD = 2;
`else
    localparam int unsigned TO   = 255;
    localparam int          HOLD = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] req = 16'h0000;
    logic        ack = 1'b0;
    logic        gv;
    logic [3:0]  gs;
    logic [15:0] goh;
    logic        to;

    rr_arbiter16 #(.TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_i          (req),
        .ack_i          (ack),
        .grant_valid_o  (gv),
        .grant_sel_o    (gs),
        .grant_onehot_o (goh),
        .timeout_o      (to)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       v;
        logic [3:0] s;
        logic       t;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic [15:0] r, input logic a);
        @(negedge clk);
        req = r;
        ack = a;
    endtask

    // Expected output change caused by the inputs just driven (visible one edge later).
    task automatic expect_ev(input logic v, input logic [3:0] s, input logic t);
        ev_t e;
        e.cyc = cyc + 1;
        e.v   = v;
        e.s   = s;
        e.t   = t;
        q.push_back(e);
    endtask

    // Monitor
    initial begin
        logic       pv;
        logic [3:0] ps;
        ev_t        e;
        pv = 1'b0;
        ps = 4'd0;
        forever begin
            @(negedge clk);
            if (rst_n && ((gv != pv) || (gv && gs != ps) || to)) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got v=%0b sel=%0d to=%0b expected none (cycle %0d)",
                             gv, gs, to, cyc);
                end else begin
                    e = q.pop_front();
                    check("ev_cycle", cyc, e.cyc);
                    check("ev_valid", {31'd0, gv}, {31'd0, e.v});
                    if (e.v) check("ev_sel", {28'd0, gs}, {28'd0, e.s});
                    check("ev_onehot", {16'd0, goh}, e.v ? (32'd1 << e.s) : 32'd0);
                    check("ev_timeout", {31'd0, to}, {31'd0, e.t});
                end
            end
            pv = gv;
            ps = gs;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, gv}, 32'd0);
        check("rst_sel", {28'd0, gs}, 32'd0);
        check("rst_onehot", {16'd0, goh}, 32'd0);
        check("rst_timeout", {31'd0, to}, 32'd0);
        rst_n = 1'b1;

        // Single request, held grant while other request bits churn
        drive(16'h0010, 1'b0); expect_ev(1'b1, 4'd4, 1'b0);
        for (int i = 0; i < HOLD; i++) drive(16'(i * 16'h1357) | 16'h0010, 1'b0);
        drive(16'h0010, 1'b1); expect_ev(1'b0, 4'd0, 1'b0);       // ptr -> 5

        // All requesting, ack every cycle: back-to-back rotation from ptr 5
        drive(16'hFFFF, 1'b0); expect_ev(1'b1, 4'd5, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            drive(16'hFFFF, 1'b1); expect_ev(1'b1, 4'((5 + i) % 16), 1'b0);
        end
        drive(16'h0000, 1'b1); expect_ev(1'b0, 4'd0, 1'b0);       // ptr -> 6

        // ptr = 14 cases
        drive(16'h2000, 1'b0); expect_ev(1'b1, 4'd13, 1'b0);
        drive(16'h2000, 1'b1); expect_ev(1'b0, 4'd0, 1'b0);       // ptr -> 14
        drive(16'h8001, 1'b0); expect_ev(1'b1, 4'd15, 1'b0);
        drive(16'h8001, 1'b1); expect_ev(1'b1, 4'd0, 1'b0);
        drive(16'h0000, 1'b1); expect_ev(1'b0, 4'd0, 1'b0);       // ptr -> 1
        drive(16'h2000, 1'b0); expect_ev(1'b1, 4'd13, 1'b0);
        drive(16'h0000, 1'b1); expect_ev(1'b0, 4'd0, 1'b0);       // ptr -> 14
        drive(16'h0001, 1'b0); expect_ev(1'b1, 4'd0, 1'b0);
        drive(16'h0000, 1'b1); expect_ev(1'b0, 4'd0, 1'b0);       // ptr -> 1

        // Withdrawal abort, then wrapped arbitration from ptr 8
        drive(16'h0080, 1'b0); expect_ev(1'b1, 4'd7, 1'b0);
        drive(16'h0000, 1'b0); expect_ev(1'b0, 4'd0, 1'b0);       // ptr -> 8
        drive(16'h0081, 1'b0); expect_ev(1'b1, 4'd0, 1'b0);
        drive(16'h0081, 1'b1); expect_ev(1'b1, 4'd7, 1'b0);
        drive(16'h0000, 1'b1); expect_ev(1'b0, 4'd0, 1'b0);       // ptr -> 8

        // ack and withdrawal together: ack wins, back-to-back grant
        drive(16'h0003, 1'b0); expect_ev(1'b1, 4'd0, 1'b0);
        drive(16'h0002, 1'b1); expect_ev(1'b1, 4'd1, 1'b0);
        drive(16'h0000, 1'b1); expect_ev(1'b0, 4'd0, 1'b0);       // ptr -> 2

        // ack in IDLE is ignored
        drive(16'h0000, 1'b1);
        drive(16'h0000, 1'b1);

        // Long hold: forced release with timeout build, held otherwise
        drive(16'h0004, 1'b0); expect_ev(1'b1, 4'd2, 1'b0);
        for (int i = 0; i < 3; i++) drive(16'h0004, 1'b0);
        drive(16'h0004, 1'b0);
`ifdef ARB_TIMEOUT_EN
        expect_ev(1'b0, 4'd0, 1'b1);
`endif
        drive(16'h0000, 1'b0);
`ifndef ARB_TIMEOUT_EN
        expect_ev(1'b0, 4'd0, 1'b0);
`endif
        // ptr -> 3; ack on the would-be expiry cycle releases without a pulse
        drive(16'h0008, 1'b0); expect_ev(1'b1, 4'd3, 1'b0);
        for (int i = 0; i < 3; i++) drive(16'h0008, 1'b0);
        drive(16'h0008, 1'b1); expect_ev(1'b0, 4'd0, 1'b0);       // ptr -> 4

        // Reset mid-grant
        drive(16'h0020, 1'b0); expect_ev(1'b1, 4'd5, 1'b0);
        drive(16'h0020, 1'b0);
        #2;
        rst_n = 1'b0;
        req   = 16'h0000;
        ack   = 1'b0;
        #1;
        check("midrst_valid", {31'd0, gv}, 32'd0);
        check("midrst_sel", {28'd0, gs}, 32'd0);
        check("midrst_onehot", {16'd0, goh}, 32'd0);
        check("midrst_timeout", {31'd0, to}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(16'hFFFF, 1'b0); expect_ev(1'b1, 4'd0, 1'b0);
        drive(16'h0000, 1'b1); expect_ev(1'b0, 4'd0, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
